// File: rtl/bcd_divisible_seq_pkg.sv
// Shared types and helpers for the sequential BCD divisibility checker.
package bcd_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_MAX = 9;

    // One Horner step of the running remainder: (10*r + n) mod divisor.
    function automatic int rem_step(input int r, input int n, input int divisor);
        return (10 * r + n) % divisor;
    endfunction

endpackage

// File: rtl/bcd_divisible_seq_if.sv
// Request/result bundle for bcd_divisible_seq; master drives start/d_in, slave returns status.
interface bcd_divisible_seq_if
    import bcd_div_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIVISOR = 11
);
    localparam int RW = $clog2(DIVISOR);

    // start is a request level sampled every clock; it is taken only while busy=0,
    // and the result (done/divisible/bcd_err/remainder) holds until the next taken start.
    logic                  start;
    logic [4*DIGITS-1:0]   d_in;
    logic                  busy;
    logic                  done;
    logic                  divisible;
    logic                  bcd_err;
    logic [RW-1:0]         remainder;
    state_t                state_dbg;

    modport master (
        output start, d_in,
        input  busy, done, divisible, bcd_err, remainder, state_dbg
    );

    modport slave (
        input  start, d_in,
        output busy, done, divisible, bcd_err, remainder, state_dbg
    );

endinterface

// File: rtl/bcd_divisible_seq_rem_step.sv
// Combinational remainder step: folds one BCD nibble into the running remainder.
module bcd_rem_step
    import bcd_div_pkg::*;
#(
    parameter int DIVISOR = 11
) (
    input  logic [$clog2(DIVISOR)-1:0] r,
    input  logic [3:0]                 nibble,
    output logic [$clog2(DIVISOR)-1:0] r_next,
    output logic                       invalid
);
    localparam int RW = $clog2(DIVISOR);

    // Invalid nibbles are still folded so every word takes the same number of cycles.
    always_comb begin
        r_next  = RW'(rem_step(int'(r), int'(nibble), DIVISOR));
        invalid = (nibble > 4'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_divisible_seq.sv
// Sequential BCD divisibility checker, one digit per clock, MSD first.
// Optional RESTART_EN: a start during processing aborts and re-latches the new word.
module bcd_divisible_seq
    import bcd_div_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIVISOR = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_divisible_seq_if.slave    bus
);
    localparam int RW = $clog2(DIVISOR);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t          state;
    logic [W-1:0]    sr_q;
    logic [RW-1:0]   r_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            div_q;
    logic            bcd_err_q;
    logic [RW-1:0]   rem_q;

    logic [RW-1:0]   r_next;
    logic            nib_bad;
    logic            start_ok;

    bcd_rem_step #(.DIVISOR(DIVISOR)) u_step (
        .r       (r_q),
        .nibble  (sr_q[W-1 -: 4]),
        .r_next  (r_next),
        .invalid (nib_bad)
    );

`ifdef RESTART_EN
    assign start_ok = bus.start;
`else
    assign start_ok = bus.start && !busy_q;
`endif

    // Results are published one clock after the last digit folds, straight from the
    // registered remainder, so the step logic never sits on the output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr_q      <= '0;
            r_q       <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div_q     <= 1'b0;
            bcd_err_q <= 1'b0;
            rem_q     <= '0;
        end else if (start_ok) begin
            state     <= RUN;
            sr_q      <= bus.d_in;
            r_q       <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            div_q     <= 1'b0;
            bcd_err_q <= 1'b0;
            rem_q     <= '0;
        end else begin
            case (state)
                RUN: begin
                    r_q   <= r_next;
                    err_q <= err_q | nib_bad;
                    sr_q  <= sr_q << 4;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (busy_q) begin
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        bcd_err_q <= err_q;
                        div_q     <= !err_q && (r_q == '0);
                        rem_q     <= err_q ? '0 : r_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.divisible = div_q;
    assign bus.bcd_err   = bcd_err_q;
    assign bus.remainder = rem_q;
    assign bus.state_dbg = state;

endmodule
